// File: rtl/mxpl_writer.sv
// rtl/mxpl_writer.sv - writes pooled max-pool results into output memory in row-major order
module mxpl_writer #(
    parameter int DATAW = 20,
    parameter int ADDRW = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ADDRW-1:0] baseAddr,
    input  logic [ADDRW-1:0] rowStride,
    input  logic [5:0]       mapW,
    input  logic [5:0]       mapH,
    input  logic             reluEn,
    input  logic [DATAW-1:0] result,
    input  logic             mxplDone,
    output logic             wen,
    output logic [ADDRW-1:0] waddr,
    output logic [DATAW-1:0] wdata,
    output logic             busy,
    output logic             layerDone,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] stride_q, stride_d;
    logic [ADDRW-1:0] row_addr_q, row_addr_d;
    logic [5:0]       map_w_q, map_w_d;
    logic [5:0]       map_h_q, map_h_d;
    logic             relu_q, relu_d;
    logic [5:0]       col_q, col_d;
    logic [5:0]       row_q, row_d;
    logic             wen_q, wen_d;
    logic [ADDRW-1:0] waddr_q, waddr_d;
    logic [DATAW-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;

    // A 6-bit size of 0 wraps to 63 here, which is exactly the last index of a 64-wide map.
    logic [5:0]       last_col, last_row;
    logic [DATAW-1:0] processed;

    assign last_col = map_w_q - 6'd1;
    assign last_row = map_h_q - 6'd1;

    // The sign bit marks a negative result; ReLU forces those to zero without changing width.
    assign processed = (relu_q && result[DATAW-1]) ? '0 : result;

    // Next-state, counter stepping and write register update.
    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        row_addr_d = row_addr_q;
        map_w_d    = map_w_q;
        map_h_d    = map_h_q;
        relu_d     = relu_q;
        col_d      = col_q;
        row_d      = row_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    stride_d   = rowStride;
                    row_addr_d = baseAddr;
                    map_w_d    = mapW;
                    map_h_d    = mapH;
                    relu_d     = reluEn;
                    col_d      = 6'd0;
                    row_d      = 6'd0;
                    err_d      = 1'b0;
                end else if (mxplDone) begin
                    err_d = 1'b1;
                end
            end
            S_RUN: begin
                if (mxplDone) begin
                    wen_d   = 1'b1;
                    waddr_d = row_addr_q + ADDRW'(col_q);
                    wdata_d = processed;
                    if (col_q == last_col) begin
                        col_d      = 6'd0;
                        row_d      = row_q + 6'd1;
                        row_addr_d = row_addr_q + stride_q;
                        if (row_q == last_row) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (mxplDone) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously so no write survives a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            stride_q   <= '0;
            row_addr_q <= '0;
            map_w_q    <= '0;
            map_h_q    <= '0;
            relu_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stride_q   <= stride_d;
            row_addr_q <= row_addr_d;
            map_w_q    <= map_w_d;
            map_h_q    <= map_h_d;
            relu_q     <= relu_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign wen       = wen_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign busy      = (state_q == S_RUN);
    assign layerDone = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_mxpl_writer.sv
// tb/tb_mxpl_writer.sv - self-checking bench for mxpl_writer
module tb_mxpl_writer;

    localparam int DATAW = 20;
    localparam int ADDRW = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [ADDRW-1:0] baseAddr = '0;
    logic [ADDRW-1:0] rowStride = '0;
    logic [5:0]       mapW = '0;
    logic [5:0]       mapH = '0;
    logic             reluEn = 1'b0;
    logic [DATAW-1:0] result = '0;
    logic             mxplDone = 1'b0;
    logic             wen;
    logic [ADDRW-1:0] waddr;
    logic [DATAW-1:0] wdata;
    logic             busy;
    logic             layerDone;
    logic             err;

    int checks = 0;
    int errors = 0;

    mxpl_writer #(.DATAW(DATAW), .ADDRW(ADDRW)) dut (
        .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr),
        .rowStride(rowStride), .mapW(mapW), .mapH(mapH), .reluEn(reluEn),
        .result(result), .mxplDone(mxplDone), .wen(wen), .waddr(waddr),
        .wdata(wdata), .busy(busy), .layerDone(layerDone), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] base;
        logic [11:0] stride;
        logic [5:0]  w;
        logic [5:0]  h;
        logic        relu;
        logic        b2b;
        int          exp_n;
        logic [11:0] exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] b, input logic [11:0] s,
                            input logic [5:0] w, input logic [5:0] h, input logic r);
        baseAddr  = b;
        rowStride = s;
        mapW      = w;
        mapH      = h;
        reluEn    = r;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic strobe(input logic [19:0] res);
        mxplDone = 1'b1;
        result   = res;
        step();
        mxplDone = 1'b0;
    endtask

    // Reference: the k-th pooled element lives at base + row*stride + col, modulo 2^ADDRW.
    function automatic logic [11:0] model_addr(input vec_t v, input int k);
        int we, r, c, a;
        we = (v.w == 0) ? 64 : int'(v.w);
        r  = k / we;
        c  = k % we;
        a  = int'(v.base) + r * int'(v.stride) + c;
        return 12'(a);
    endfunction

    function automatic logic [19:0] model_data(input logic relu, input logic [19:0] res);
        if (relu && $signed(res) < 0) return 20'd0;
        return res;
    endfunction

    task automatic run_layer(input vec_t v, input string tag);
        int we, he, n, nw;
        logic [11:0] got_last;
        logic [19:0] res;
        we = (v.w == 0) ? 64 : int'(v.w);
        he = (v.h == 0) ? 64 : int'(v.h);
        n  = we * he;
        nw = 0;
        got_last = '0;
        do_start(v.base, v.stride, v.w, v.h, v.relu);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".err_cleared"}, 32'(err), 32'd0);
        for (int k = 0; k < n; k++) begin
            if (!v.b2b) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    chk({tag, ".idle_wen"}, 32'(wen), 32'd0);
                    chk({tag, ".idle_busy"}, 32'(busy), 32'd1);
                end
            end
            res = 20'($urandom);
            strobe(res);
            chk({tag, ".wen"}, 32'(wen), 32'd1);
            chk({tag, ".waddr"}, 32'(waddr), 32'(model_addr(v, k)));
            chk({tag, ".wdata"}, 32'(wdata), 32'(model_data(v.relu, res)));
            chk({tag, ".layerDone"}, 32'(layerDone), 32'(k == n - 1));
            if (wen) begin
                nw++;
                got_last = waddr;
            end
        end
        chk({tag, ".nwrites"}, 32'(nw), 32'(v.exp_n));
        chk({tag, ".last_addr"}, 32'(got_last), 32'(v.exp_last));
        step();
        chk({tag, ".after_wen"}, 32'(wen), 32'd0);
        chk({tag, ".after_done"}, 32'(layerDone), 32'd0);
        chk({tag, ".after_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        vec_t rv;
        tbl[0] = '{12'h100, 12'h008, 6'd3, 6'd2, 1'b0, 1'b0, 6,  12'h10A};
        tbl[1] = '{12'hFFE, 12'h001, 6'd1, 6'd3, 1'b1, 1'b0, 3,  12'h000};
        tbl[2] = '{12'h040, 12'h004, 6'd4, 6'd1, 1'b0, 1'b1, 4,  12'h043};
        tbl[3] = '{12'h800, 12'h040, 6'd0, 6'd1, 1'b1, 1'b0, 64, 12'h83F};
        tbl[4] = '{12'h000, 12'h041, 6'd1, 6'd0, 1'b0, 1'b1, 64, 12'hFFF};
        tbl[5] = '{12'hF00, 12'h080, 6'd2, 6'd3, 1'b1, 1'b0, 6,  12'h001};

        // Reset state
        reset = 1'b0;
        repeat (2) step();
        chk("rst.wen", 32'(wen), 32'd0);
        chk("rst.waddr", 32'(waddr), 32'd0);
        chk("rst.wdata", 32'(wdata), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.layerDone", 32'(layerDone), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_layer(tbl[i], $sformatf("tbl%0d", i));
        end

        // ReLU on a negative value, then the same value passed through
        do_start(12'h000, 12'h001, 6'd1, 6'd1, 1'b1);
        strobe(20'hFFFFB);
        chk("relu_on.wdata", 32'(wdata), 32'h0);
        chk("relu_on.layerDone", 32'(layerDone), 32'd1);
        step();
        do_start(12'h000, 12'h001, 6'd1, 6'd1, 1'b0);
        strobe(20'hFFFFB);
        chk("relu_off.wdata", 32'(wdata), 32'hFFFFB);
        step();

        // Strobe while idle is dropped and flagged; an accepted start clears the flag
        strobe(20'h00123);
        chk("idle_strobe.wen", 32'(wen), 32'd0);
        chk("idle_strobe.err", 32'(err), 32'd1);
        step();
        chk("idle_strobe.err_sticky", 32'(err), 32'd1);
        do_start(12'h010, 12'h001, 6'd1, 6'd1, 1'b0);
        chk("start.err_clear", 32'(err), 32'd0);

        // Strobe landing in DONE is dropped and flagged
        strobe(20'h00007);
        chk("done.wen", 32'(wen), 32'd1);
        chk("done.layerDone", 32'(layerDone), 32'd1);
        strobe(20'h00009);
        chk("done_strobe.wen", 32'(wen), 32'd0);
        chk("done_strobe.err", 32'(err), 32'd1);
        chk("done_strobe.busy", 32'(busy), 32'd0);

        // Start while running must not re-arm the layer
        do_start(12'h200, 12'h010, 6'd2, 6'd1, 1'b0);
        strobe(20'h00001);
        chk("rearm.addr0", 32'(waddr), 32'h200);
        do_start(12'h300, 12'h010, 6'd5, 6'd5, 1'b0);
        strobe(20'h00002);
        chk("rearm.addr1", 32'(waddr), 32'h201);
        chk("rearm.layerDone", 32'(layerDone), 32'd1);
        step();

        // Reset mid-row discards the layer; strobes afterwards are errors
        do_start(12'h100, 12'h008, 6'd3, 6'd2, 1'b0);
        strobe(20'h00011);
        strobe(20'h00022);
        chk("midrst.pre_waddr", 32'(waddr), 32'h101);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst.wen", 32'(wen), 32'd0);
        chk("midrst.waddr", 32'(waddr), 32'd0);
        chk("midrst.wdata", 32'(wdata), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        step();
        reset = 1'b1;
        step();
        strobe(20'h00033);
        chk("postrst.wen", 32'(wen), 32'd0);
        chk("postrst.err", 32'(err), 32'd1);
        strobe(20'h00044);
        chk("postrst.wen2", 32'(wen), 32'd0);

        // Randomized layers checked against the address/data model
        for (int i = 0; i < 8; i++) begin
            rv.base     = 12'($urandom);
            rv.stride   = 12'($urandom);
            rv.w        = 6'($urandom_range(1, 6));
            rv.h        = 6'($urandom_range(1, 5));
            rv.relu     = 1'($urandom);
            rv.b2b      = 1'($urandom);
            rv.exp_n    = int'(rv.w) * int'(rv.h);
            rv.exp_last = model_addr(rv, rv.exp_n - 1);
            run_layer(rv, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mxpl_writer.md
MXPL_WRITER -- requirements
Module: mxpl_writer

Interface
REQ-001 SHALL have parameter DATAW, default 20, meaning the width of pooled data words.
REQ-002 SHALL have parameter ADDRW, default 12, meaning the width of output memory addresses.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that arms the writer for one pooled layer.
REQ-006 SHALL have port baseAddr, input, ADDRW bits: address of pooled element (row 0, col 0), sampled on accepted start.
REQ-007 SHALL have port rowStride, input, ADDRW bits: address distance between pooled rows, sampled on accepted start.
REQ-008 SHALL have port mapW, input, 6 bits: pooled columns per row (1..63), sampled on accepted start.
REQ-009 SHALL have port mapH, input, 6 bits: pooled rows (1..63), sampled on accepted start.
REQ-010 SHALL have port reluEn, input, 1 bit: when 1, negative results are written as 0; sampled on accepted start.
REQ-011 SHALL have port result, input, DATAW bits, signed: pooled value from the max-pool unit, valid only while mxplDone = 1.
REQ-012 SHALL have port mxplDone, input, 1 bit: one-cycle strobe marking result valid.
REQ-013 SHALL have port wen, output, 1 bit: output-memory write enable.
REQ-014 SHALL have port waddr, output, ADDRW bits: write address.
REQ-015 SHALL have port wdata, output, DATAW bits: write data.
REQ-016 SHALL have port busy, output, 1 bit: high in state RUN.
REQ-017 SHALL have port layerDone, output, 1 bit: one-cycle pulse after the last write of the layer.
REQ-018 SHALL have port err, output, 1 bit: sticky flag for a strobe received outside RUN.

Function
REQ-019 SHALL implement FSM states IDLE, RUN and DONE.
REQ-020 SHALL transition IDLE -> RUN on start = 1, latching baseAddr, rowStride, mapW, mapH and reluEn, and clearing col, row and rowAddr (rowAddr = baseAddr).
REQ-021 SHALL ignore start while in RUN or DONE.
REQ-022 SHALL, in RUN on mxplDone = 1, register wen = 1, wdata = processed result and waddr = rowAddr + col in the next cycle (latency 1).
REQ-023 SHALL compute processed result as (reluEn and result < 0) ? 0 : result, with a signed comparison and no width change.
REQ-024 SHALL, after each accepted strobe, increment col; when col = mapW-1, clear col, increment row and add rowStride to rowAddr (ADDRW-bit modulo wrap, no saturation).
REQ-025 SHALL, on the strobe where row = mapH-1 and col = mapW-1, go RUN -> DONE; that write still issues.
REQ-026 SHALL pulse layerDone for exactly the one cycle in DONE, concurrent with the final wen, then return to IDLE.
REQ-027 SHALL keep wen low in every cycle not following an accepted strobe, and hold waddr and wdata at their last values.
REQ-028 SHALL, on mxplDone = 1 in IDLE or DONE, drop the strobe (no write) and set err; err clears only on reset or an accepted start.
REQ-029 SHALL, on consecutive-cycle strobes in RUN, issue one write per cycle with no loss.
REQ-030 SHALL treat mapW = 0 or mapH = 0 as 64.

Reset
REQ-031 SHALL, while reset = 0, asynchronously force state IDLE, wen = 0, waddr = 0, wdata = 0, busy = 0, layerDone = 0, err = 0 and all counters and latched configuration to 0.
REQ-032 SHALL discard any layer in progress when reset asserts mid-RUN; no write completes after the reset edge.

Verification
REQ-033 SHALL cover: start with base = 0x100, stride = 8, mapW = 3, mapH = 2, then 6 strobes -> writes at 0x100, 0x101, 0x102, 0x108, 0x109, 0x10A; layerDone coincides with the 0x10A write.
REQ-034 SHALL cover: reluEn = 1 with result = -5 -> wdata = 0; reluEn = 0 with result = -5 -> wdata = 0xFFFFB (20-bit).
REQ-035 SHALL cover: strobe while IDLE -> no wen, err = 1; next accepted start -> err = 0.
REQ-036 SHALL cover: 4 back-to-back strobes with mapW = 4, mapH = 1 -> 4 consecutive wen cycles, then layerDone, then IDLE.
REQ-037 SHALL cover: reset = 0 asserted mid-row after 2 of 6 writes -> outputs clear immediately; after release with no start, strobes produce no writes and set err.
REQ-038 SHALL cover: base = 0xFFE, stride = 1, mapW = 1, mapH = 3 -> writes at 0xFFE, 0xFFF, 0x000.
